// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    HALT  = 2'd2,
    FAULT = 2'd3
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0100_0000;
  localparam int          INSTR_BYTES      = 4;

endpackage

// File: rtl/fetch_perf_cnt.sv
// Saturating 32-bit event counter used by the optional fetch performance counters.
module fetch_perf_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  output logic [31:0] count
);

  // Counter sticks at all-ones instead of wrapping, so a long run never reads as a short one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (inc && (count != 32'hFFFF_FFFF)) begin
      count <= count + 32'd1;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer for a 1-cycle-latency ROM: owns the PC, handles redirects/halt/fault.
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            halt_req,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            rom_rd,
  output logic [XLEN-1:0] rom_addr,
  input  logic [XLEN-1:0] rom_rdata,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  output logic            halted,
  output logic            fault
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_stall,
  output logic [31:0]     perf_squash
`endif
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pend_pc;
  logic            pend;
  logic            misaligned;
  logic            issue;

  assign misaligned = redirect_valid && (redirect_pc[1:0] != 2'b00);

  // A new fetch may go out when the previous one is consumed, squashed by a redirect, or absent.
  always_comb begin
    issue       = 1'b0;
    rom_addr    = redirect_valid ? redirect_pc : pc_q;
    instr_valid = pend && !redirect_valid && (state_q != FAULT);
    state_d     = state_q;

    if ((state_q == RUN) && !halt_req && !misaligned &&
        (!pend || instr_ready || redirect_valid)) begin
      issue = 1'b1;
    end

    case (state_q)
      IDLE:    if (start)     state_d = RUN;
      RUN:     if (halt_req)  state_d = HALT;
      HALT:    if (!halt_req) state_d = RUN;
      FAULT:   state_d = FAULT;
      default: state_d = IDLE;
    endcase

    if (misaligned) begin
      state_d = FAULT;
    end
  end

  assign rom_rd   = issue;
  assign instr    = rom_rdata;
  assign instr_pc = pend_pc;
  assign halted   = (state_q == HALT) && !pend;
  assign fault    = (state_q == FAULT);

  // An aligned redirect that cannot issue still retargets the PC and drops the pending instr.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      pend    <= 1'b0;
      pend_pc <= '0;
    end else begin
      state_q <= state_d;
      if (misaligned) begin
        pend <= 1'b0;
      end else if (issue) begin
        pc_q    <= rom_addr + XLEN'(INSTR_BYTES);
        pend    <= 1'b1;
        pend_pc <= rom_addr;
      end else if (redirect_valid) begin
        pc_q <= redirect_pc;
        pend <= 1'b0;
      end else if (instr_valid && instr_ready) begin
        pend <= 1'b0;
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  fetch_perf_cnt u_cnt_fetched (
    .clk   (clk),
    .rst   (rst),
    .inc   (instr_valid && instr_ready),
    .count (perf_fetched)
  );

  fetch_perf_cnt u_cnt_stall (
    .clk   (clk),
    .rst   (rst),
    .inc   (instr_valid && !instr_ready),
    .count (perf_stall)
  );

  fetch_perf_cnt u_cnt_squash (
    .clk   (clk),
    .rst   (rst),
    .inc   (redirect_valid && pend),
    .count (perf_squash)
  );
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl with a behavioural 1-cycle ROM; counter test when FETCH_PERF_CNT_EN is set.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        halt_req;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        rom_rd;
  logic [31:0] rom_addr;
  logic [31:0] rom_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        halted;
  logic        fault;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;
  logic [31:0] perf_squash;
`endif

  int          total = 0;
  int          bad = 0;
  logic [31:0] sb[$];
  logic [31:0] exp_pc;
  logic [31:0] iss;

  always #5 clk = ~clk;

  fetch_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .halt_req       (halt_req),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .rom_rd         (rom_rd),
    .rom_addr       (rom_addr),
    .rom_rdata      (rom_rdata),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .halted         (halted),
    .fault          (fault)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_stall     (perf_stall),
    .perf_squash    (perf_squash)
`endif
  );

  function automatic logic [31:0] rom_fn(input logic [31:0] a);
    return 32'h1300_0013 ^ {a[23:2], 10'h2A5};
  endfunction

  // ROM holds its data when not strobed.
  always @(posedge clk) begin
    if (rom_rd) rom_rdata <= rom_fn(rom_addr);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0; start = 1'b0; halt_req = 1'b0; redirect_valid = 1'b0;
    redirect_pc = 32'h0; instr_ready = 1'b0;
    tick; tick;
    @(negedge clk);
    total++; if (rom_rd !== 1'b0) begin bad++; $display("[TB] FAIL reset_rd got %b want 0", rom_rd); end
    total++; if (instr_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid got %b want 0", instr_valid); end
    total++; if (halted !== 1'b0) begin bad++; $display("[TB] FAIL reset_halted got %b want 0", halted); end
    total++; if (fault !== 1'b0) begin bad++; $display("[TB] FAIL reset_fault got %b want 0", fault); end
    total++; if (rom_addr !== 32'h0100_0000) begin bad++; $display("[TB] FAIL reset_pc got %h want 01000000", rom_addr); end
    tick;
  endtask

  task automatic test_stream;
    rst = 1'b1; instr_ready = 1'b1; start = 1'b1;
    @(negedge clk);
    total++; if (rom_rd !== 1'b0) begin bad++; $display("[TB] FAIL idle_rd got %b want 0", rom_rd); end
    tick;
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      iss = 32'h0100_0000 + 32'(4 * i);
      total++;
      if (rom_rd !== 1'b1 || rom_addr !== iss) begin
        bad++; $display("[TB] FAIL stream_issue rd=%b addr=%h want rd=1 addr=%h", rom_rd, rom_addr, iss);
      end
      if (i > 0) begin
        total++;
        if (sb.size() == 0) begin bad++; $display("[TB] FAIL stream_sb empty queue"); end
        else begin
          exp_pc = sb.pop_front();
          if (instr_valid !== 1'b1 || instr_pc !== exp_pc || instr !== rom_fn(exp_pc)) begin
            bad++; $display("[TB] FAIL stream_out v=%b pc=%h instr=%h want pc=%h instr=%h",
                            instr_valid, instr_pc, instr, exp_pc, rom_fn(exp_pc));
          end
        end
      end
      sb.push_back(iss);
      tick;
    end
  endtask

  task automatic test_stall;
    instr_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++;
      if (rom_rd !== 1'b0 || instr_valid !== 1'b1 || instr_pc !== 32'h0100_0008 ||
          instr !== rom_fn(32'h0100_0008)) begin
        bad++; $display("[TB] FAIL stall_hold rd=%b v=%b pc=%h instr=%h want rd=0 v=1 pc=01000008",
                        rom_rd, instr_valid, instr_pc, instr);
      end
      tick;
    end
    instr_ready = 1'b1;
    @(negedge clk);
    total++;
    if (rom_rd !== 1'b1 || rom_addr !== 32'h0100_000C) begin
      bad++; $display("[TB] FAIL stall_resume rd=%b addr=%h want rd=1 addr=0100000c", rom_rd, rom_addr);
    end
    total++;
    if (sb.size() == 0) begin bad++; $display("[TB] FAIL stall_sb empty queue"); end
    else begin
      exp_pc = sb.pop_front();
      if (instr_valid !== 1'b1 || instr_pc !== exp_pc) begin
        bad++; $display("[TB] FAIL stall_out v=%b pc=%h want pc=%h", instr_valid, instr_pc, exp_pc);
      end
    end
    sb.push_back(32'h0100_000C);
    tick;
  endtask

  task automatic test_redirect;
    redirect_valid = 1'b1; redirect_pc = 32'h0100_0040;
    @(negedge clk);
    total++;
    if (instr_valid !== 1'b0 || rom_rd !== 1'b1 || rom_addr !== 32'h0100_0040) begin
      bad++; $display("[TB] FAIL redir_squash v=%b rd=%b addr=%h want v=0 rd=1 addr=01000040",
                      instr_valid, rom_rd, rom_addr);
    end
    if (sb.size() > 0) exp_pc = sb.pop_front();
    sb.push_back(32'h0100_0040);
    tick;
    redirect_valid = 1'b0;
    for (int j = 0; j < 2; j++) begin
      @(negedge clk);
      iss = 32'h0100_0044 + 32'(4 * j);
      total++;
      if (rom_rd !== 1'b1 || rom_addr !== iss) begin
        bad++; $display("[TB] FAIL redir_issue rd=%b addr=%h want addr=%h", rom_rd, rom_addr, iss);
      end
      total++;
      if (sb.size() == 0) begin bad++; $display("[TB] FAIL redir_sb empty queue"); end
      else begin
        exp_pc = sb.pop_front();
        if (instr_valid !== 1'b1 || instr_pc !== exp_pc || instr !== rom_fn(exp_pc)) begin
          bad++; $display("[TB] FAIL redir_out v=%b pc=%h instr=%h want pc=%h", instr_valid, instr_pc, instr, exp_pc);
        end
      end
      sb.push_back(iss);
      tick;
    end
  endtask

  task automatic test_halt;
    halt_req = 1'b1;
    @(negedge clk);
    total++;
    if (rom_rd !== 1'b0 || halted !== 1'b0) begin
      bad++; $display("[TB] FAIL halt_enter rd=%b halted=%b want rd=0 halted=0", rom_rd, halted);
    end
    total++;
    if (sb.size() == 0) begin bad++; $display("[TB] FAIL halt_sb empty queue"); end
    else begin
      exp_pc = sb.pop_front();
      if (instr_valid !== 1'b1 || instr_pc !== exp_pc) begin
        bad++; $display("[TB] FAIL halt_drain v=%b pc=%h want v=1 pc=%h", instr_valid, instr_pc, exp_pc);
      end
    end
    tick;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      total++;
      if (halted !== 1'b1 || rom_rd !== 1'b0 || instr_valid !== 1'b0) begin
        bad++; $display("[TB] FAIL halt_idle halted=%b rd=%b v=%b want 1 0 0", halted, rom_rd, instr_valid);
      end
      tick;
    end
    halt_req = 1'b0;
    @(negedge clk);
    total++;
    if (rom_rd !== 1'b0) begin bad++; $display("[TB] FAIL halt_exit_rd got %b want 0", rom_rd); end
    tick;
    @(negedge clk);
    total++;
    if (rom_rd !== 1'b1 || rom_addr !== 32'h0100_004C) begin
      bad++; $display("[TB] FAIL halt_resume rd=%b addr=%h want rd=1 addr=0100004c", rom_rd, rom_addr);
    end
    sb.push_back(32'h0100_004C);
    tick;
  endtask

  task automatic test_fault;
    redirect_valid = 1'b1; redirect_pc = 32'h0100_0042;
    @(negedge clk);
    total++;
    if (rom_rd !== 1'b0 || instr_valid !== 1'b0) begin
      bad++; $display("[TB] FAIL fault_entry rd=%b v=%b want 0 0", rom_rd, instr_valid);
    end
    if (sb.size() > 0) exp_pc = sb.pop_front();
    tick;
    redirect_valid = 1'b0; start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++;
      if (fault !== 1'b1 || rom_rd !== 1'b0 || instr_valid !== 1'b0 || halted !== 1'b0) begin
        bad++; $display("[TB] FAIL fault_sticky fault=%b rd=%b v=%b halted=%b want 1 0 0 0",
                        fault, rom_rd, instr_valid, halted);
      end
      tick;
    end
    start = 1'b0; rst = 1'b0;
    #1;
    total++;
    if (fault !== 1'b0 || rom_addr !== 32'h0100_0000 || rom_rd !== 1'b0 || instr_valid !== 1'b0) begin
      bad++; $display("[TB] FAIL fault_reset fault=%b addr=%h rd=%b v=%b want 0 01000000 0 0",
                      fault, rom_addr, rom_rd, instr_valid);
    end
    tick;
    rst = 1'b1;
    tick;
  endtask

  task automatic test_wrap;
    instr_ready = 1'b1; start = 1'b1;
    tick;
    start = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    @(negedge clk);
    total++;
    if (rom_rd !== 1'b1 || rom_addr !== 32'hFFFF_FFFC) begin
      bad++; $display("[TB] FAIL wrap_issue rd=%b addr=%h want rd=1 addr=fffffffc", rom_rd, rom_addr);
    end
    sb.push_back(32'hFFFF_FFFC);
    tick;
    redirect_valid = 1'b0;
    @(negedge clk);
    total++;
    if (rom_rd !== 1'b1 || rom_addr !== 32'h0000_0000) begin
      bad++; $display("[TB] FAIL wrap_next rd=%b addr=%h want rd=1 addr=00000000", rom_rd, rom_addr);
    end
    total++;
    if (sb.size() == 0) begin bad++; $display("[TB] FAIL wrap_sb empty queue"); end
    else begin
      exp_pc = sb.pop_front();
      if (instr_valid !== 1'b1 || instr_pc !== exp_pc || instr !== rom_fn(exp_pc)) begin
        bad++; $display("[TB] FAIL wrap_out v=%b pc=%h instr=%h want pc=%h", instr_valid, instr_pc, instr, exp_pc);
      end
    end
    sb.push_back(32'h0000_0000);
    tick;
    halt_req = 1'b1;
    @(negedge clk);
    total++;
    if (sb.size() == 0) begin bad++; $display("[TB] FAIL wrap_sb2 empty queue"); end
    else begin
      exp_pc = sb.pop_front();
      if (instr_valid !== 1'b1 || instr_pc !== exp_pc || instr !== rom_fn(exp_pc)) begin
        bad++; $display("[TB] FAIL wrap_last v=%b pc=%h instr=%h want pc=%h", instr_valid, instr_pc, instr, exp_pc);
      end
    end
    tick;
    @(negedge clk);
    total++;
    if (halted !== 1'b1) begin bad++; $display("[TB] FAIL wrap_halted got %b want 1", halted); end
    tick;
  endtask

`ifdef FETCH_PERF_CNT_EN
  task automatic test_perf;
    rst = 1'b0; halt_req = 1'b0; redirect_valid = 1'b0;
    tick;
    rst = 1'b1; instr_ready = 1'b1; start = 1'b1;
    tick;
    start = 1'b0;
    tick; tick;
    instr_ready = 1'b0;
    tick; tick;
    instr_ready = 1'b1;
    tick;
    redirect_valid = 1'b1; redirect_pc = 32'h0100_0200;
    tick;
    redirect_valid = 1'b0;
    tick; tick;
    halt_req = 1'b1;
    tick;
    @(negedge clk);
    total++;
    if (perf_fetched !== 32'd5) begin bad++; $display("[TB] FAIL perf_fetched got %0d want 5", perf_fetched); end
    total++;
    if (perf_stall !== 32'd2) begin bad++; $display("[TB] FAIL perf_stall got %0d want 2", perf_stall); end
    total++;
    if (perf_squash !== 32'd1) begin bad++; $display("[TB] FAIL perf_squash got %0d want 1", perf_squash); end
    tick;
  endtask
`endif

  initial begin
    test_reset;
    test_stream;
    test_stall;
    test_redirect;
    test_halt;
    test_fault;
    test_wrap;
`ifdef FETCH_PERF_CNT_EN
    test_perf;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
